// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// The optional grant counters are enabled with DM_ARB_PERF_EN.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Wide enough for RD_LAT-1 with RD_LAT up to 7.
  localparam int CNT_W = 3;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return (id == REQ_LDR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arb_rr_pick.sv
// Two-way round-robin pick: the sole requester wins, otherwise the one
// that was not served last.
module dm_arb_rr_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_winner
);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    o_winner = 2'b00;
    case (i_req)
      2'b01:   o_winner = 2'b01;
      2'b10:   o_winner = 2'b10;
      2'b11:   o_winner = (i_last == REQ_CPU) ? 2'b10 : 2'b01;
      default: o_winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving a CPU path and a loader/debug port turns at a
// single-port data memory. Define DM_ARB_PERF_EN to add per-requester grant counters.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          DM_CS,
  output logic          DM_R,
  output logic          DM_W,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
`ifdef DM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_grant0,
  output logic [15:0]   perf_grant1
`endif
);

  localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(RD_LAT - 1);

  state_t           r_state;
  logic             r_owner;
  logic             r_we;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;
  logic [1:0]       r_done;
  logic             r_cs;
  logic             r_rd;
  logic             r_wr;

  logic [1:0]       w_pick;
  logic             w_sel;
  logic             w_sel_we;

  dm_arb_rr_pick u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_winner (w_pick)
  );

  assign w_sel    = w_pick[1];
  assign w_sel_we = we[w_sel];

  // Reset is folded in so no grant is offered while the arbiter is held in reset.
  assign gnt      = (r_state == ST_IDLE && reset) ? w_pick : 2'b00;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign DM_CS    = r_cs;
  assign DM_R     = r_rd;
  assign DM_W     = r_wr;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples values from before the edge.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= REQ_CPU;
      r_we    <= 1'b0;
      r_last  <= REQ_LDR;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 2'b00;
      r_cs    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (|w_pick) begin
            r_owner <= w_sel;
            r_we    <= w_sel_we;
            r_addr  <= w_sel ? addr1 : addr0;
            r_wdata <= w_sel ? wdata1 : wdata0;
            r_cs    <= 1'b1;
            r_wr    <= w_sel_we;
            r_rd    <= ~w_sel_we;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_done  <= id_to_onehot(r_owner);
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= LP_CNT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= dm_rdata;
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_done  <= id_to_onehot(r_owner);
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DM_ARB_PERF_EN
  logic [15:0] r_perf0;
  logic [15:0] r_perf1;

  assign perf_grant0 = r_perf0;
  assign perf_grant1 = r_perf1;

  // Saturating: counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_perf0 <= '0;
      r_perf1 <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_pick[0] && r_perf0 != 16'hFFFF) r_perf0 <= r_perf0 + 16'd1;
      if (w_pick[1] && r_perf1 != 16'hFFFF) r_perf1 <= r_perf1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed steps, a latency-modelled memory,
// and a grant/done scoreboard. Define DM_ARB_PERF_EN to also exercise the grant counters.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b0;
  logic [1:0]    req    = 2'b00;
  logic [1:0]    we     = 2'b00;
  logic [AW-1:0] addr0  = '0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          DM_CS;
  logic          DM_R;
  logic          DM_W;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
`ifdef DM_ARB_PERF_EN
  logic [15:0]   perf_grant0;
  logic [15:0]   perf_grant1;
`endif

  dm_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt      (gnt),
    .done     (done),
    .rdata    (rdata),
    .DM_CS    (DM_CS),
    .DM_R     (DM_R),
    .DM_W     (DM_W),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
`ifdef DM_ARB_PERF_EN
    ,
    .perf_grant0 (perf_grant0),
    .perf_grant1 (perf_grant1)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Memory environment: data appears RD_LAT edges after it is read.
  logic [DW-1:0] mem  [logic [AW-1:0]];
  logic [DW-1:0] pipe [RD_LAT];
  assign dm_rdata = pipe[RD_LAT-1];

  always @(posedge clk_in) begin
    for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (DM_CS && DM_R) ? (mem.exists(dm_addr) ? mem[dm_addr] : '0) : 32'hBAD0BAD0;
    if (DM_CS && DM_W) mem[dm_addr] = dm_wdata;
  end

  // Scoreboard: expectation pushed on each grant, popped on each done.
  typedef struct {
    logic          id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    int            t_gnt;
  } exp_t;

  exp_t          sb [$];
  logic          gnt_order [$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic          tb_last = 1'b1;
  int            nclk    = 0;
  exp_t          mon_e;
  logic          mon_w;

  always @(negedge clk_in) begin
    nclk++;
    if (!reset) begin
      tb_last = 1'b1;
      sb.delete();
    end else begin
      if (gnt !== 2'b00) begin
        mon_w = (req == 2'b11) ? ~tb_last : req[1];
        check("gnt_winner", gnt, mon_w ? 2'b10 : 2'b01);
        mon_e.id    = mon_w;
        mon_e.wr    = we[mon_w];
        mon_e.addr  = mon_w ? addr1 : addr0;
        mon_e.t_gnt = nclk;
        mon_e.rdata = '0;
        if (mon_e.wr) model_mem[mon_e.addr] = mon_w ? wdata1 : wdata0;
        else if (model_mem.exists(mon_e.addr)) mon_e.rdata = model_mem[mon_e.addr];
        sb.push_back(mon_e);
        gnt_order.push_back(mon_w);
      end
      if (done !== 2'b00) begin
        if (sb.size() == 0) begin
          check("done_unexpected", done, 2'b00);
        end else begin
          mon_e = sb.pop_front();
          check("done_onehot", done, mon_e.id ? 2'b10 : 2'b01);
          check("done_latency", nclk - mon_e.t_gnt, mon_e.wr ? 2 : 2 + RD_LAT);
          if (!mon_e.wr) check("load_rdata", rdata, mon_e.rdata);
          tb_last = mon_e.id;
        end
      end
    end
  end

  task automatic request(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    @(posedge clk_in); #1;
    we[id] = w;
    if (id == 0) begin addr0 = a; wdata0 = d; end
    else         begin addr1 = a; wdata1 = d; end
    req[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (gnt[id]) begin got = 1'b1; break; end
    end
    if (!got) check("gnt_timeout", 0, 1);
    @(posedge clk_in); #1;
    req[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (sb.size() == 0 && done == 2'b00 && !DM_CS) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk_in); #1;
  endtask

  initial begin
    int start;
    bit got4;
`ifdef DM_ARB_PERF_EN
    logic [15:0] pg1_before;
`endif
    mem[32'h20]       = 32'h1234_5678;
    model_mem[32'h20] = 32'h1234_5678;

    // Held in reset with both requesting: everything quiet.
    req = 2'b11;
    #50;
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_rdata", rdata, 0);
    check("rst_cs", DM_CS, 0);
    check("rst_r", DM_R, 0);
    check("rst_w", DM_W, 0);
    check("rst_addr", dm_addr, 0);
    check("rst_wdata", dm_wdata, 0);
    #52 reset = 1'b1;
    #1;
    check("first_gnt", gnt, 2'b01);
    req = 2'b00;
    @(posedge clk_in); #1;
    check("idle_gnt", gnt, 2'b00);
    check("idle_cs", DM_CS, 0);

    // Single store from requester 0.
    request(0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("st_cs", DM_CS, 1);
    check("st_w", DM_W, 1);
    check("st_r", DM_R, 0);
    check("st_addr", dm_addr, 32'h10);
    check("st_wdata", dm_wdata, 32'hDEADBEEF);
    @(posedge clk_in); #1;
    check("st_done", done, 2'b01);
    check("st_done_cs", DM_CS, 0);

    // Single load from requester 1.
    request(1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("ld_r_held", DM_R, 1);
      check("ld_addr", dm_addr, 32'h20);
      check("ld_gnt_busy", gnt, 2'b00);
      @(posedge clk_in); #1;
    end
    check("ld_r_drop", DM_R, 0);
    check("ld_done", done, 2'b10);
    check("ld_rdata", rdata, 32'h1234_5678);

    // Contention, raised in the same cycle as the previous done.
    we = 2'b11; addr0 = 32'h40; wdata0 = 32'hA0A0A0A0; addr1 = 32'h44; wdata1 = 32'hB1B1B1B1;
    start = gnt_order.size();
    req = 2'b11;
    got4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (DM_CS) check("busy_no_gnt", gnt, 2'b00);
      if (gnt_order.size() >= start + 4) begin got4 = 1'b1; break; end
    end
    if (!got4) check("rr_timeout", 0, 1);
    @(posedge clk_in); #1;
    req = 2'b00;
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      if (gnt_order.size() > start + k) check("rr_order", gnt_order[start+k], k[0]);
    end

    // Cross read-back of the contention stores.
    request(0, 1'b0, 32'h44, 32'h0);
    wait_idle();
    request(1, 1'b0, 32'h40, 32'h0);
    wait_idle();

    // Reset in the middle of a load.
    request(1, 1'b0, 32'h20, 32'h0);
    @(posedge clk_in); #1;
    #2 reset = 1'b0;
    #1;
    check("rstmid_cs", DM_CS, 0);
    check("rstmid_r", DM_R, 0);
    check("rstmid_done", done, 2'b00);
    we = 2'b00; addr0 = 32'h20; addr1 = 32'h10;
    req = 2'b11;
    #10;
    check("rstmid_done_hold", done, 2'b00);
    @(posedge clk_in); #2 reset = 1'b1;
    #1;
    check("rstmid_first_gnt", gnt, 2'b01);
    @(posedge clk_in); #1;
    req = 2'b00;
    wait_idle();

    // Low address bits pass through unaligned.
    request(0, 1'b1, 32'h47, 32'h5A5A5A5A);
    check("unaligned_addr", dm_addr, 32'h47);
    wait_idle();

    // Nothing requested: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("noreq_gnt", gnt, 2'b00);
      check("noreq_cs", DM_CS, 0);
      check("noreq_done", done, 2'b00);
    end

`ifdef DM_ARB_PERF_EN
    pg1_before = perf_grant1;
    we = 2'b01; addr0 = 32'h80; wdata0 = 32'h1;
    @(posedge clk_in); #1;
    req = 2'b01;
    repeat (3 * 70000 + 10) @(posedge clk_in);
    #1 req = 2'b00;
    wait_idle();
    check("perf0_sat", perf_grant0, 16'hFFFF);
    check("perf1_hold", perf_grant1, pg1_before);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (DM_CS/DM_R/DM_W strobes) between two requesters.
  - Requester 0: CPU load/store path.
  - Requester 1: program loader / debug port.
- Round-robin arbitration; one transaction in flight at a time; fixed memory read latency.
- Sits between the CPU top and the DM instance; the memory sees one master.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from the ACCESS-cycle edge to valid dm_rdata; legal 1..7.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; must hold with we/addr/wdata stable until gnt sampled high.
- we  in  2  per-requester write enable (1 = store, 0 = load).
- addr0, addr1  in  AW  per-requester word address.
- wdata0, wdata1  in  DW  per-requester store data.
- gnt  out  2  combinational one-hot accept; meaningful only in IDLE.
- done  out  2  registered one-hot completion pulse, 1 cycle.
- rdata  out  DW  load data; valid only while done is high for a load.
- DM_CS  out  1  memory chip select.
- DM_R  out  1  memory read strobe.
- DM_W  out  1  memory write strobe.
- dm_addr  out  AW  memory address.
- dm_wdata  out  DW  memory write data.
- dm_rdata  in  DW  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; last=1, so requester 0 wins first.
  - done, DM_CS, DM_R, DM_W = 0; dm_addr, dm_wdata, rdata = 0; latency counter = 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If req != 0, pick the winner: the sole requester, or, if both request, the one != last.
  - gnt[winner]=1 combinationally.
  - At the edge: latch owner, we, addr, wdata; next state ACCESS.
  - gnt=0 in all other states.
- ACCESS (exactly 1 cycle):
  - DM_CS=1, DM_W=we_l, DM_R=~we_l; dm_addr/dm_wdata driven from latches.
  - Strobes are registered outputs.
  - Next: store -> DONE; load -> WAIT with counter = RD_LAT-1.
- WAIT:
  - DM_CS/DM_R held high, addr held.
  - Counter decrements; when 0, capture dm_rdata into rdata and go to DONE.
  - With RD_LAT=1, WAIT lasts 1 cycle.
- DONE:
  - done[owner]=1 for 1 cycle; strobes 0; last <= owner; next IDLE.
  - rdata holds until the next load completes.
- Latency from gnt edge to done high: store = 2 cycles; load = 2+RD_LAT cycles.
- Throughput: one transaction per 3 (store) or 3+RD_LAT (load) cycles.
- Boundary rules:
  - Only IDLE samples req. A req raised or dropped mid-transaction has no effect until IDLE.
  - A new req in the same cycle as done is sampled at the next IDLE.
  - Starvation bound: with both requesting continuously, grants alternate strictly 0,1,0,1.
  - reset mid-ACCESS/WAIT: strobes drop immediately (asynchronous); no done; the transaction is lost and the requester must re-request.
  - addr[1:0] passes through unchanged; alignment is the requester's responsibility.
  - req=2'b00 in IDLE: stay IDLE, all outputs idle.

Optional Feature:
- Macro: DM_ARB_PERF_EN.
- Defined:
  - Adds ports perf_grant0, perf_grant1 (out, 16 each).
  - Saturating counts of grants per requester; hold at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dm_arb_pkg:
  - FSM state encoding (2-bit).
  - Requester IDs REQ_CPU=0, REQ_LDR=1.
  - RD_LAT counter width constant (3).
- Sub-module dm_arb_rr_pick: combinational 2-way round-robin; inputs req[1:0] and last; outputs one-hot winner.

Test Plan:
- Reset: hold reset=0 for 100 ns with req=2'b11 -> all outputs 0, gnt=0. Release -> first gnt=2'b01.
- Single store, req0 only: we0=1, addr0=32'h10, wdata0=32'hDEADBEEF.
  - Next cycle: DM_CS=1, DM_W=1, DM_R=0, dm_addr=32'h10.
  - One cycle later: done=2'b01.
- Single load, req1, RD_LAT=3: memory returns 32'h1234_5678.
  - DM_R held high 4 cycles.
  - done=2'b10 with rdata=32'h12345678 exactly 5 cycles after gnt.
- Contention: req=2'b11 held for 4 transactions -> grant order 0,1,0,1; no cycle with both gnt bits set.
- Reset mid-WAIT: drop reset during a load -> DM_CS/DM_R fall immediately, no done pulse. After release -> IDLE with last=1.
- DM_ARB_PERF_EN defined: 70000 grants to requester 0 -> perf_grant0=16'hFFFF, perf_grant1 unchanged.
